mmio_router: RTL and testbench
==============================

MMIO_ROUTER -- requirements
Module: mmio_router

Interface
REQ-001 Parameter NUM_DEV, default 3: number of downstream device ports, range 1..8.
REQ-002 Parameter DEPTH, default 4: maximum outstanding requests, power of two, range 1..8.
REQ-003 Parameter DEV_BASE[NUM_DEV], default {MMAP_RAM_BEGIN, MMAP_ROM_BEGIN, DBG_ADDR}: per-device base address.
REQ-004 Parameter DEV_SIZE[NUM_DEV], default {RAM size, ROM size, 8}: per-device window size in bytes, nonzero.
REQ-005 clk  input  1: single clock, all state on rising edge.
REQ-006 rst  input  1: reset, asynchronous, active-high.
REQ-007 req_core  Membus.slave  XLEN/MEMBUS_DATA_WIDTH: core request/response port.
REQ-008 dev_membus[NUM_DEV]  Membus.master  XLEN/MEMBUS_DATA_WIDTH: device ports, index = device number.
REQ-009 rerr  output  1: qualifies req_core.rvalid; 1 = decode error (unmapped address).
REQ-010 busy  output  1: one or more requests outstanding.

Function
REQ-011 Decode: device i matches when DEV_BASE[i] <= addr <= DEV_BASE[i]+DEV_SIZE[i]-1; lowest index wins on overlap; no match = UNMAPPED.
REQ-012 Translation: dev_membus[i].addr SHALL equal req_core.addr - DEV_BASE[i]; wen, wdata and wmask pass through unchanged.
REQ-013 A request is accepted when req_core.valid && req_core.ready are both high; the accepted request drives only the matched device's valid in the same cycle.
REQ-014 Unselected device ports SHALL drive valid=0, addr=0, wen=0, wdata=0, wmask=0.
REQ-015 req_core.ready = !full_eff && target_ok && (UNMAPPED || dev_membus[target].ready).
  - full_eff = full && !pop.
  - Combinational path from rvalid to ready is permitted.
REQ-016 target_ok: the tag FIFO is empty, or the target equals the most recently pushed tag.
  - This guarantees in-order responses.
  - A different target stalls until the FIFO drains.
REQ-017 Each accepted request pushes its tag (device index, or UNMAPPED) into a DEPTH-entry tag FIFO.
REQ-018 Response: while the FIFO is non-empty and the head tag = i, req_core.rvalid/rdata SHALL mirror dev_membus[i].rvalid/rdata; rerr=0; pop occurs on that rvalid.
REQ-019 Head tag = UNMAPPED:
  - The block SHALL assert rvalid=1, rdata=0, rerr=1 for exactly one cycle, then pop.
  - Earliest response is the cycle after acceptance.
  - Unmapped writes have no side effect.
REQ-020 Latency added by the block: zero cycles, both request and response paths.
REQ-021 Simultaneous push and pop are legal in any state, including full; occupancy is then unchanged.
REQ-022 Device rvalid arriving while that device is not the head tag, or while the FIFO is empty, SHALL be ignored.
REQ-023 With the FIFO empty: req_core.rvalid=0, rdata=0, rerr=0.
REQ-024 Occupancy counter width is clog2(DEPTH)+1; read and write pointers wrap modulo DEPTH.
REQ-025 busy = (occupancy != 0).

Reset
REQ-026 On rst, asynchronously:
  - Occupancy and pointers are cleared.
  - rvalid, rerr and busy are 0.
  - All device valids are 0.
  - req_core.ready follows REQ-015 with an empty FIFO.
REQ-027 Reset mid-transaction discards all outstanding tags; late device responses after reset are dropped per REQ-022.

Structure
REQ-028 Shared package eei holds: XLEN, MEMBUS_DATA_WIDTH, MMAP_* constants, the UNMAPPED tag encoding (value NUM_DEV), and the tag width clog2(NUM_DEV+1).
REQ-029 The tag FIFO SHALL be sub-module mmio_tag_fifo, parameterised by WIDTH and DEPTH, with push/pop/full/empty/head outputs.
REQ-030 Decode SHALL be a function local to mmio_router; no other sub-modules.

Verification
REQ-031 RAM (device 0, ready=1, 1-cycle rvalid): read at MMAP_RAM_BEGIN+0x10 -> dev0.addr=0x10; rdata 0xDEADBEEF returned the next cycle; rerr=0; busy falls after the response.
REQ-032 Four back-to-back RAM reads, DEPTH=4, device holds rvalid low -> ready drops on the 5th request; releasing one rvalid re-raises ready in the same cycle (push and pop together).
REQ-033 RAM read followed by a ROM read while the RAM read is outstanding -> ROM valid is held 0 and ready=0 until the RAM rvalid; the ROM request then issues in that cycle; responses arrive in order.
REQ-034 Write to 0x0 (unmapped) -> no device valid asserted; the next cycle gives rvalid=1, rerr=1, rdata=0 for one cycle.
REQ-035 Assert rst with 2 requests outstanding, then deliver device rvalid -> rvalid stays 0; busy=0; a new request is accepted normally.
REQ-036 Write to DBG_ADDR+7, then DBG_ADDR+8 -> the first goes to the debug device with addr 7; the second decodes per the map (UNMAPPED if no window covers it).

Source files
------------

// File: rtl/mmio_router_pkg.sv
// Shared execution-environment constants for the MMIO router: bus widths,
// the memory map, and helpers for sizing device tags.
package eei;

    localparam int XLEN              = 32;
    localparam int MEMBUS_DATA_WIDTH = 32;
    localparam int MEMBUS_MASK_WIDTH = MEMBUS_DATA_WIDTH / 8;

    localparam logic [XLEN-1:0] MMAP_ROM_BEGIN = 32'h0000_1000;
    localparam logic [XLEN-1:0] MMAP_ROM_SIZE  = 32'h0000_1000;
    localparam logic [XLEN-1:0] MMAP_RAM_BEGIN = 32'h8000_0000;
    localparam logic [XLEN-1:0] MMAP_RAM_SIZE  = 32'h0100_0000;
    localparam logic [XLEN-1:0] DBG_ADDR       = 32'h4000_0000;
    localparam logic [XLEN-1:0] DBG_SIZE       = 32'd8;

    // Tags are device indices 0..num_dev-1 plus one extra code (num_dev)
    // that marks an unmapped access.
    function automatic int tag_width(input int num_dev);
        return $clog2(num_dev + 1);
    endfunction

    function automatic int unmapped_tag(input int num_dev);
        return num_dev;
    endfunction

endpackage

// File: rtl/mmio_tag_fifo.sv
// Small circular FIFO holding the device tag of every outstanding request,
// so responses can be steered back in issue order. Also remembers the most
// recently pushed tag so the router can tell whether a new request targets
// the same device as the tail.
module mmio_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         last,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is allowed when a pop frees a slot the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointer, occupancy and last-tag bookkeeping; reset drops every outstanding tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            last   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
                last   <= push_data;
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/mmio_router.sv
// Routes core memory requests to one of NUM_DEV address windows with zero
// added latency, translating addresses to window offsets, and returns
// responses strictly in order. Unmapped accesses get an error response
// generated locally one cycle after acceptance.
module mmio_router
    import eei::*;
#(
    parameter int NUM_DEV = 3,
    parameter int DEPTH   = 4,
    parameter logic [XLEN-1:0] DEV_BASE [NUM_DEV] = '{MMAP_RAM_BEGIN, MMAP_ROM_BEGIN, DBG_ADDR},
    parameter logic [XLEN-1:0] DEV_SIZE [NUM_DEV] = '{MMAP_RAM_SIZE, MMAP_ROM_SIZE, DBG_SIZE}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_core_valid,
    output logic                          req_core_ready,
    input  logic [XLEN-1:0]               req_core_addr,
    input  logic                          req_core_wen,
    input  logic [MEMBUS_DATA_WIDTH-1:0]  req_core_wdata,
    input  logic [MEMBUS_MASK_WIDTH-1:0]  req_core_wmask,
    output logic                          req_core_rvalid,
    output logic [MEMBUS_DATA_WIDTH-1:0]  req_core_rdata,
    output logic [NUM_DEV-1:0]            dev_valid,
    input  logic [NUM_DEV-1:0]            dev_ready,
    output logic [XLEN-1:0]               dev_addr  [NUM_DEV],
    output logic [NUM_DEV-1:0]            dev_wen,
    output logic [MEMBUS_DATA_WIDTH-1:0]  dev_wdata [NUM_DEV],
    output logic [MEMBUS_MASK_WIDTH-1:0]  dev_wmask [NUM_DEV],
    input  logic [NUM_DEV-1:0]            dev_rvalid,
    input  logic [MEMBUS_DATA_WIDTH-1:0]  dev_rdata [NUM_DEV],
    output logic                          rerr,
    output logic                          busy
);

    localparam int TAG_W = tag_width(NUM_DEV);
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [TAG_W-1:0] UNMAPPED = TAG_W'(unmapped_tag(NUM_DEV));

    logic [TAG_W-1:0] target;
    logic [TAG_W-1:0] head_tag;
    logic [TAG_W-1:0] last_tag;
    logic [CW-1:0]    count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             accept;
    logic             full_eff;
    logic             target_ok;
    logic             target_ready;

    // Lowest-numbered window wins on overlap, hence the descending scan.
    function automatic logic [TAG_W-1:0] decode(input logic [XLEN-1:0] addr);
        logic [TAG_W-1:0] tag;
        tag = UNMAPPED;
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            if (addr >= DEV_BASE[i] && (addr - DEV_BASE[i]) < DEV_SIZE[i]) begin
                tag = TAG_W'(i);
            end
        end
        return tag;
    endfunction

    assign target = decode(req_core_addr);

    mmio_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .pop       (pop),
        .push_data (target),
        .head      (head_tag),
        .last      (last_tag),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    // Response path: mirror the head device, or synthesise an error beat for an unmapped head.
    always_comb begin
        req_core_rvalid = 1'b0;
        req_core_rdata  = '0;
        rerr            = 1'b0;
        if (!fifo_empty) begin
            if (head_tag == UNMAPPED) begin
                req_core_rvalid = 1'b1;
                rerr            = 1'b1;
            end else begin
                for (int i = 0; i < NUM_DEV; i++) begin
                    if (head_tag == TAG_W'(i)) begin
                        req_core_rvalid = dev_rvalid[i];
                        req_core_rdata  = dev_rdata[i];
                    end
                end
            end
        end
    end

    assign pop = req_core_rvalid;

    // Readiness of whatever the current address decodes to; unmapped is always ready.
    always_comb begin
        target_ready = (target == UNMAPPED);
        for (int i = 0; i < NUM_DEV; i++) begin
            if (target == TAG_W'(i)) begin
                target_ready = dev_ready[i];
            end
        end
    end

    // A target switch waits until the FIFO drains, counting a last entry that pops this cycle.
    assign full_eff       = fifo_full && !pop;
    assign target_ok      = fifo_empty || (count == CW'(1) && pop) || (target == last_tag);
    assign req_core_ready = !full_eff && target_ok && target_ready;
    assign accept         = req_core_valid && req_core_ready && !rst;
    assign busy           = (count != '0);

    // Request fan-out: only the decoded device sees the request, all others are held at zero.
    always_comb begin
        for (int i = 0; i < NUM_DEV; i++) begin
            dev_valid[i] = 1'b0;
            dev_addr[i]  = '0;
            dev_wen[i]   = 1'b0;
            dev_wdata[i] = '0;
            dev_wmask[i] = '0;
            if (req_core_valid && target == TAG_W'(i)) begin
                dev_valid[i] = accept;
                dev_addr[i]  = req_core_addr - DEV_BASE[i];
                dev_wen[i]   = req_core_wen;
                dev_wdata[i] = req_core_wdata;
                dev_wmask[i] = req_core_wmask;
            end
        end
    end

endmodule

// File: tb/tb_mmio_router.sv
// Self-checking bench for mmio_router: directed scenarios for the memory-map
// corner cases followed by randomized traffic, all checked against a
// queue-based reference model of the outstanding requests.
module tb_mmio_router;
    import eei::*;

    localparam int NDEV  = 3;
    localparam int DEPTH = 4;
    localparam int UNM   = NDEV;

    logic                          clk = 1'b0;
    logic                          rst = 1'b0;
    logic                          core_valid = 1'b0;
    logic                          core_ready;
    logic [XLEN-1:0]               core_addr = '0;
    logic                          core_wen = 1'b0;
    logic [MEMBUS_DATA_WIDTH-1:0]  core_wdata = '0;
    logic [MEMBUS_MASK_WIDTH-1:0]  core_wmask = '0;
    logic                          core_rvalid;
    logic [MEMBUS_DATA_WIDTH-1:0]  core_rdata;
    logic [NDEV-1:0]               dev_valid;
    logic [NDEV-1:0]               dev_ready = '0;
    logic [XLEN-1:0]               dev_addr  [NDEV];
    logic [NDEV-1:0]               dev_wen;
    logic [MEMBUS_DATA_WIDTH-1:0]  dev_wdata [NDEV];
    logic [MEMBUS_MASK_WIDTH-1:0]  dev_wmask [NDEV];
    logic [NDEV-1:0]               dev_rvalid = '0;
    logic [MEMBUS_DATA_WIDTH-1:0]  dev_rdata [NDEV] = '{32'h0, 32'h0, 32'h0};
    logic                          rerr;
    logic                          busy;

    always #5 clk = ~clk;

    mmio_router #(
        .NUM_DEV (NDEV),
        .DEPTH   (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_core_valid  (core_valid),
        .req_core_ready  (core_ready),
        .req_core_addr   (core_addr),
        .req_core_wen    (core_wen),
        .req_core_wdata  (core_wdata),
        .req_core_wmask  (core_wmask),
        .req_core_rvalid (core_rvalid),
        .req_core_rdata  (core_rdata),
        .dev_valid       (dev_valid),
        .dev_ready       (dev_ready),
        .dev_addr        (dev_addr),
        .dev_wen         (dev_wen),
        .dev_wdata       (dev_wdata),
        .dev_wmask       (dev_wmask),
        .dev_rvalid      (dev_rvalid),
        .dev_rdata       (dev_rdata),
        .rerr            (rerr),
        .busy            (busy)
    );

    logic [XLEN-1:0] ref_base [NDEV] = '{MMAP_RAM_BEGIN, MMAP_ROM_BEGIN, DBG_ADDR};
    logic [XLEN-1:0] ref_size [NDEV] = '{MMAP_RAM_SIZE, MMAP_ROM_SIZE, DBG_SIZE};

    // Reference model: the list of outstanding destinations, oldest first.
    int tag_q[$];
    int n_compared   = 0;
    int n_mismatched = 0;
    bit exp_pop;
    bit exp_accept;
    int exp_target;

    task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s at %0t: observed %0h expected %0h", tag, $time, observed, expected);
        end
    endtask

    function automatic int refDecode(input logic [XLEN-1:0] a);
        for (int i = 0; i < NDEV; i++) begin
            if (a >= ref_base[i] && (a - ref_base[i]) < ref_size[i]) return i;
        end
        return UNM;
    endfunction

    task automatic applyStimulus(input logic v, input logic [XLEN-1:0] a, input logic w,
                                 input logic [31:0] d, input logic [3:0] m);
        core_valid = v;
        core_addr  = a;
        core_wen   = w;
        core_wdata = d;
        core_wmask = m;
    endtask

    // Called just after a falling edge once inputs are driven: predict and compare every output.
    task automatic checkCycle();
        logic        e_rvalid;
        logic        e_rerr;
        logic [31:0] e_rdata;
        logic        e_ready;
        logic [NDEV-1:0] e_valid;
        bit drained, tok, room, dev_ok;
        #1;
        e_rvalid = 1'b0;
        e_rerr   = 1'b0;
        e_rdata  = '0;
        if (tag_q.size() > 0) begin
            if (tag_q[0] == UNM) begin
                e_rvalid = 1'b1;
                e_rerr   = 1'b1;
            end else begin
                e_rvalid = dev_rvalid[tag_q[0]];
                e_rdata  = dev_rdata[tag_q[0]];
            end
        end
        exp_pop    = e_rvalid;
        exp_target = refDecode(core_addr);
        drained    = (tag_q.size() == 0) || (tag_q.size() == 1 && exp_pop);
        tok        = drained || (tag_q.size() > 0 && tag_q[tag_q.size() - 1] == exp_target);
        room       = (tag_q.size() < DEPTH) || exp_pop;
        dev_ok     = 1'b1;
        if (exp_target != UNM) dev_ok = dev_ready[exp_target];
        e_ready    = room && tok && dev_ok;
        exp_accept = core_valid && e_ready && !rst;
        e_valid    = '0;
        if (exp_accept && exp_target != UNM) e_valid[exp_target] = 1'b1;

        checkOutput("rvalid", core_rvalid, e_rvalid);
        checkOutput("rerr",   rerr,        e_rerr);
        checkOutput("rdata",  core_rdata,  e_rdata);
        checkOutput("ready",  core_ready,  e_ready);
        checkOutput("busy",   busy,        tag_q.size() != 0);
        checkOutput("dev_valid", dev_valid, e_valid);
        for (int i = 0; i < NDEV; i++) begin
            logic [68:0] e_bus;
            e_bus = '0;
            if (core_valid && exp_target == i)
                e_bus = {core_addr - ref_base[i], core_wen, core_wdata, core_wmask};
            checkOutput($sformatf("dev%0d_bus", i),
                        {dev_addr[i], dev_wen[i], dev_wdata[i], dev_wmask[i]}, e_bus);
        end
    endtask

    // Commit this cycle's predicted pop/push to the model and move to the next falling edge.
    task automatic advanceCycle();
        if (exp_pop) void'(tag_q.pop_front());
        if (exp_accept) tag_q.push_back(exp_target);
        @(negedge clk);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, 1'b0, '0, '0);
        dev_rvalid = '0;
        #2 rst = 1'b1;
        tag_q.delete();
        #1;
        checkOutput("rst_rvalid",    core_rvalid, 1'b0);
        checkOutput("rst_rerr",      rerr,        1'b0);
        checkOutput("rst_busy",      busy,        1'b0);
        checkOutput("rst_dev_valid", dev_valid,   '0);
        checkOutput("rst_ready",     core_ready,  1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [XLEN-1:0] randAddr();
        case ($urandom_range(0, 5))
            0: return MMAP_RAM_BEGIN + ($urandom & 32'h00FF_FFFC);
            1: return MMAP_ROM_BEGIN + ($urandom % 32'h1000);
            2: return DBG_ADDR + $urandom_range(0, 9);
            3: return $urandom;
            4: return ($urandom_range(0, 1) != 0) ? MMAP_RAM_BEGIN - 1 : MMAP_ROM_BEGIN + MMAP_ROM_SIZE;
            default: return '0;
        endcase
    endfunction

    initial begin
        @(negedge clk);
        doReset();

        // Single RAM read with a one-cycle device response.
        dev_ready = '1;
        applyStimulus(1'b1, MMAP_RAM_BEGIN + 32'h10, 1'b0, '0, '0);
        checkCycle();
        checkOutput("ram_offset", dev_addr[0], 32'h10);
        checkOutput("ram_sel", dev_valid, 3'b001);
        advanceCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, '0);
        dev_rvalid   = 3'b001;
        dev_rdata[0] = 32'hDEAD_BEEF;
        checkCycle();
        checkOutput("ram_rdata", core_rdata, 32'hDEAD_BEEF);
        advanceCycle();
        dev_rvalid = '0;
        checkCycle();
        checkOutput("ram_busy_fall", busy, 1'b0);
        advanceCycle();

        // Fill the tag FIFO, then free one slot and push in the same cycle.
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(1'b1, MMAP_RAM_BEGIN + 32'(k * 4), 1'b0, '0, '0);
            checkCycle();
            checkOutput("fill_ready", core_ready, 1'b1);
            advanceCycle();
        end
        applyStimulus(1'b1, MMAP_RAM_BEGIN + 32'h40, 1'b0, '0, '0);
        checkCycle();
        checkOutput("full_stall", core_ready, 1'b0);
        advanceCycle();
        dev_rvalid   = 3'b001;
        dev_rdata[0] = 32'h1234_5678;
        checkCycle();
        checkOutput("full_pushpop", core_ready, 1'b1);
        advanceCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, '0);
        for (int k = 0; k < DEPTH; k++) begin
            checkCycle();
            advanceCycle();
        end
        dev_rvalid = '0;

        // A ROM request behind an outstanding RAM read must wait for the RAM response.
        applyStimulus(1'b1, MMAP_RAM_BEGIN + 32'h20, 1'b0, '0, '0);
        checkCycle();
        advanceCycle();
        applyStimulus(1'b1, MMAP_ROM_BEGIN + 32'h8, 1'b0, '0, '0);
        checkCycle();
        checkOutput("switch_stall", {core_ready, dev_valid}, 4'b0000);
        advanceCycle();
        dev_rvalid   = 3'b001;
        dev_rdata[0] = 32'hAAAA_0001;
        checkCycle();
        checkOutput("switch_issue", {core_ready, dev_valid}, 4'b1010);
        checkOutput("rom_offset", dev_addr[1], 32'h8);
        advanceCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, '0);
        dev_rvalid   = 3'b010;
        dev_rdata[1] = 32'hBBBB_0002;
        checkCycle();
        checkOutput("rom_rdata", core_rdata, 32'hBBBB_0002);
        advanceCycle();
        dev_rvalid = '0;

        // Unmapped write at address zero: no device touched, one error beat next cycle.
        applyStimulus(1'b1, '0, 1'b1, 32'hCAFE_F00D, 4'hF);
        checkCycle();
        checkOutput("unm_no_dev", dev_valid, 3'b000);
        advanceCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, '0);
        checkCycle();
        checkOutput("unm_err_beat", {core_rvalid, rerr, core_rdata}, {2'b11, 32'h0});
        advanceCycle();
        checkCycle();
        checkOutput("unm_one_beat", core_rvalid, 1'b0);
        advanceCycle();

        // Last byte of the debug window, then the first byte past it.
        applyStimulus(1'b1, DBG_ADDR + 32'd7, 1'b1, 32'h0000_0077, 4'h1);
        checkCycle();
        checkOutput("dbg_offset", {dev_valid, dev_addr[2]}, {3'b100, 32'd7});
        advanceCycle();
        applyStimulus(1'b1, DBG_ADDR + 32'd8, 1'b1, 32'h0000_0088, 4'h1);
        dev_rvalid = 3'b100;
        checkCycle();
        checkOutput("dbg_past_end", {core_ready, dev_valid}, 4'b1000);
        advanceCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, '0);
        dev_rvalid = '0;
        checkCycle();
        checkOutput("dbg_past_err", rerr, 1'b1);
        advanceCycle();

        // Reset with two reads in flight; the late device response must vanish.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, MMAP_RAM_BEGIN + 32'(k * 8), 1'b0, '0, '0);
            checkCycle();
            advanceCycle();
        end
        doReset();
        dev_rvalid = 3'b001;
        checkCycle();
        checkOutput("late_rsp_drop", {core_rvalid, busy}, 2'b00);
        advanceCycle();
        dev_rvalid = '0;
        applyStimulus(1'b1, MMAP_RAM_BEGIN + 32'h100, 1'b0, '0, '0);
        checkCycle();
        checkOutput("post_rst_accept", {core_ready, dev_valid}, 4'b1001);
        advanceCycle();

        // Randomized traffic with random device back-pressure and spurious responses.
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) doReset();
            applyStimulus($urandom_range(0, 9) < 7, randAddr(), 1'($urandom), $urandom, 4'($urandom));
            for (int i = 0; i < NDEV; i++) begin
                dev_ready[i]  = ($urandom_range(0, 3) != 0);
                dev_rvalid[i] = ($urandom_range(0, 9) < 4);
                dev_rdata[i]  = $urandom;
            end
            checkCycle();
            advanceCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
